// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_loader_pkg;

    localparam int unsigned CHAIN_LEN_DEF = 64;
    localparam int unsigned MARK_W_DEF    = 4;
    localparam int unsigned MARKER_DEF    = 32'b1010;
    localparam int unsigned DATA_W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_e;

    // Wide enough to hold shift numbers 0..CHAIN_LEN+MARK_W.
    function automatic int unsigned shift_cnt_w(input int unsigned chain_len,
                                                input int unsigned mark_w);
        return $clog2(chain_len + mark_w + 1);
    endfunction

    function automatic int unsigned bytes_required(input int unsigned chain_len,
                                                   input int unsigned data_w);
        return (chain_len + data_w - 1) / data_w;
    endfunction

    function automatic int unsigned bit_cnt_w(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/ccff_byte_serializer.sv
// Holds one host byte and hands it out MSB-first, one bit per take.
module ccff_byte_serializer
    import ccff_loader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              arm,
    input  logic              take,
    input  logic              stop,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bit_c,
    output logic              bit_vld_c
);

    localparam int unsigned     BC_W = bit_cnt_w(DATA_W);
    localparam logic [BC_W-1:0] FULL = BC_W'(DATA_W);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   cnt_q, cnt_d;
    logic              rdy_q, rdy_d;

    // stop drops whatever is left; a new byte is only taken while empty.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (stop) begin
            cnt_d = '0;
        end else if (s_valid && rdy_q) begin
            shreg_d = s_data;
            cnt_d   = FULL;
        end else if (take && (cnt_q != '0)) begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - BC_W'(1);
        end
        rdy_d = arm && (cnt_d == '0);
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

    assign s_ready   = rdy_q;
    assign bit_c     = shreg_q[DATA_W-1];
    assign bit_vld_c = (cnt_q != '0);

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads the fabric configuration chain: marker first, then host bytes MSB-first,
// and checks the marker as it comes back out of ccff_tail.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned        CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int unsigned        MARK_W    = MARK_W_DEF,
    parameter logic [MARK_W-1:0]  MARKER    = MARK_W'(MARKER_DEF),
    parameter int unsigned        DATA_W    = DATA_W_DEF
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned      TOTAL  = CHAIN_LEN + MARK_W;
    localparam int unsigned      CNT_W  = shift_cnt_w(CHAIN_LEN, MARK_W);
    localparam logic [CNT_W-1:0] T_C    = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] MARK_C = CNT_W'(MARK_W);
    localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(CHAIN_LEN + MARK_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  issue_q, issue_d;
    logic [CNT_W-1:0]  shift_q, shift_d;
    logic [MARK_W-1:0] mark_sr_q, mark_sr_d;
    logic [MARK_W-1:0] chk_sr_q, chk_sr_d;
    logic              head_q, head_d;
    logic              chain_en_q, chain_en_d;
    logic              shifted_q, shifted_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              take_c;
    logic              stop_c;
    logic              arm_c;
    logic              ser_bit_c;
    logic              ser_vld_c;

    ccff_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .arm        (arm_c),
        .take       (take_c),
        .stop       (stop_c),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .bit_c      (ser_bit_c),
        .bit_vld_c  (ser_vld_c)
    );

    // issue_q counts bits launched into head_q; shift_q counts chain edges
    // that have actually happened, one cycle behind.
    always_comb begin
        state_d    = state_q;
        issue_d    = issue_q;
        mark_sr_d  = mark_sr_q;
        chk_sr_d   = chk_sr_q;
        error_d    = error_q;
        head_d     = 1'b0;
        chain_en_d = 1'b0;
        take_c     = 1'b0;
        stop_c     = 1'b0;
        shift_d    = shift_q + CNT_W'(chain_en_q);
        shifted_d  = chain_en_q;

        // Marker bit for shift n is at the tail the cycle after that shift.
        if (shifted_q && (shift_q >= WIN_LO) && (shift_q <= WIN_HI)) begin
            chk_sr_d = chk_sr_q << 1;
            if (ccff_tail != chk_sr_q[MARK_W-1]) begin
                error_d = 1'b1;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = MARK;
                    issue_d   = '0;
                    shift_d   = '0;
                    error_d   = 1'b0;
                    mark_sr_d = MARKER;
                    chk_sr_d  = MARKER;
                end
            end
            MARK: begin
                chain_en_d = 1'b1;
                head_d     = mark_sr_q[MARK_W-1];
                mark_sr_d  = mark_sr_q << 1;
                issue_d    = issue_q + CNT_W'(1);
                if (issue_d == MARK_C) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (ser_vld_c && (issue_q < T_C)) begin
                    take_c     = 1'b1;
                    chain_en_d = 1'b1;
                    head_d     = ser_bit_c;
                    issue_d    = issue_q + CNT_W'(1);
                    if (issue_d == T_C) begin
                        stop_c = 1'b1;
                    end
                end
                // Leave only once shift T has happened so error is settled.
                if (chain_en_q && (shift_q == LAST_C)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        arm_c  = (state_d == LOAD) && (issue_d < T_C);
        busy_d = (state_d == MARK) || (state_d == LOAD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q    <= IDLE;
            issue_q    <= '0;
            shift_q    <= '0;
            mark_sr_q  <= '0;
            chk_sr_q   <= '0;
            head_q     <= 1'b0;
            chain_en_q <= 1'b0;
            shifted_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            shift_q    <= shift_d;
            mark_sr_q  <= mark_sr_d;
            chk_sr_q   <= chk_sr_d;
            head_q     <= head_d;
            chain_en_q <= chain_en_d;
            shifted_q  <= shifted_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign ccff_head = head_q;
    assign chain_en  = chain_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Drives the configuration flip-flop chain that runs through the connection and switch blocks, from `ccff_head` in to `ccff_tail` out.
- Accepts configuration bytes from the bitstream host over a valid/ready stream and serializes them MSB-first onto the chain's `ccff_head`.
- Gates fabric chain shifting through `chain_en`.
- Checks chain integrity by pushing a known marker ahead of the configuration and checking that it emerges intact at the chain's `ccff_tail`.

Parameters:
- CHAIN_LEN, 64, total configuration bits in the chain (must be >= 1).
- MARK_W, 4, marker length in bits (must be >= 1).
- MARKER, 4'b1010, marker pattern; bit MARK_W-1 is shifted first.
- DATA_W, 8, host byte width.

Ports:
- prog_clk  in  1  programming clock; sole clock.
- prog_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load sequence.
- s_data  in  DATA_W  configuration byte; MSB is shifted first.
- s_valid  in  1  `s_data` valid.
- s_ready  out  1  loader can accept a byte.
- ccff_head  out  1  serial data into the chain head.
- ccff_tail  in  1  serial data returned from the chain tail.
- chain_en  out  1  enable for the fabric `prog_clk` gate; the chain shifts on the edge ending any cycle where `chain_en`=1.
- busy  out  1  a sequence is in progress.
- done  out  1  sequence complete; sticky until the next start.
- error  out  1  marker mismatch seen; sticky until the next start.

Behaviour:
- Clock and reset: one clock (`prog_clk`). Reset is synchronous and active-high (`prog_reset`).
- Reset values: all outputs 0; state IDLE; counters 0.
- Output timing: `ccff_head` and `chain_en` are registered and change together. `ccff_head` is meaningful only when `chain_en`=1.
- Shift numbering: shifts are numbered 1..T, where T = MARK_W + CHAIN_LEN.

State machine:
- IDLE:
  - `s_ready`=0, `busy`=0.
  - `start` -> MARK; clears `done`, `error` and the shift counter.
  - `start` in MARK or LOAD is ignored.
- MARK:
  - `busy`=1.
  - Emits MARKER bits, one per cycle with `chain_en`=1, MSB first; no host data is needed.
  - After MARK_W shifts -> LOAD.
- LOAD:
  - `busy`=1. Holds an internal DATA_W-bit bit buffer plus a bit counter.
  - `s_ready`=1 only while the buffer is empty. A byte is accepted on `s_valid`&&`s_ready`.
  - Each following cycle emits one buffer bit with `chain_en`=1.
  - When the buffer is empty and no byte is available, `chain_en`=0 (stall); the chain holds its contents.
  - Throughput: one byte per DATA_W+1 cycles is acceptable.
  - When shift T completes, the remaining buffer bits are discarded (last byte: only its top CHAIN_LEN mod DATA_W bits are used, or all bits if the remainder is 0), `s_ready`=0 -> DONE.
  - Host must send exactly ceil(CHAIN_LEN/DATA_W) bytes. Extra bytes are not accepted.
- DONE:
  - `done`=1, `busy`=0, `chain_en`=0.
  - `start` -> MARK, with the same clearing as from IDLE.

Integrity check:
- Marker bit i (0 = first shifted) reaches `ccff_tail` after shift CHAIN_LEN+i.
- A registered "shifted" flag marks the cycle after each shift edge. In that cycle, if the shift number n satisfies CHAIN_LEN <= n <= CHAIN_LEN+MARK_W-1, `ccff_tail` is compared with MARKER bit (MARK_W-1-(n-CHAIN_LEN)).
- Any mismatch sets `error`, which stays set until the next start.
- Samples taken during stalls are ignored.
- All compares finish no later than the cycle of shift T, so `error` is final when `done` rises.

Boundary cases:
- CHAIN_LEN < DATA_W: a single byte is used.
- `s_valid` low mid-load: chain stalls with no lost bits.
- `prog_reset` mid-sequence: returns to IDLE next edge with `chain_en`=0. The partially shifted fabric contents are left as-is; the host must restart.

Decomposition:
- Package `ccff_loader_pkg`:
  - state enum {IDLE, MARK, LOAD, DONE};
  - shift-counter width constant $clog2(CHAIN_LEN+MARK_W+1);
  - bytes-required constant.
- Sub-module `ccff_byte_serializer`:
  - byte buffer, bit counter and `s_ready` generation;
  - bit/valid output to the main FSM, with a "stop" input that discards remaining bits.

Test Plan (bench models the chain as a CHAIN_LEN-bit shift register clocked when `chain_en`=1, CHAIN_LEN=10, MARK_W=4, MARKER=4'b1010):
1. Reset mid-LOAD: `prog_reset` high one cycle -> next cycle all outputs 0, state IDLE; a following `start` runs a full sequence normally.
2. Normal load: `start`, then bytes 0xA5, 0xC0 presented continuously -> exactly 14 `chain_en` cycles; model contents 10'b1010010111; `done`=1, `error`=0; 0xC0 low 6 bits unused.
3. Host stalls: insert 5 idle cycles with `s_valid`=0 between the bytes -> `chain_en`=0 during the gap, same final contents, `error`=0.
4. Broken chain: bench forces `ccff_tail`=0 constantly -> `error`=1 when `done` rises (marker bits 1 mismatch).
5. Start ignored and back-to-back runs: `start` pulsed during LOAD -> ignored, sequence completes unchanged. Then `start` in DONE with bytes 0xFF, 0xFF -> `done`/`error` cleared at start; final contents all 1s, `error`=0.
